// File: rtl/hazard_forward_controller_pkg.sv
// hazard_pkg: shared definitions for the hazard/forwarding controller.
//   - FWD_* : execute-stage operand mux select encoding
//   - e_rec_t / mw_rec_t : shadow destination-register records per stage
//   - br_state_t : branch-flush FSM states
//   - reg_match() : "this stage writes the register being read" test
// Register specifiers are stored zero-extended to REG_AW_MAX bits, so the
// controller's REG_ADDR_W parameter must not exceed REG_AW_MAX.
package hazard_pkg;

    localparam int REG_AW_MAX = 8;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef logic [REG_AW_MAX-1:0] reg_addr_t;

    // Execute-stage record: sources are kept so forwarding can be decided
    // without any input from the real ID/EX register.
    typedef struct packed {
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      reg_write;
        logic      mem_to_reg;
    } e_rec_t;

    // Memory / writeback records only need the destination.
    typedef struct packed {
        reg_addr_t rd;
        logic      reg_write;
    } mw_rec_t;

    typedef enum logic {
        BR_IDLE,
        BR_FLUSH
    } br_state_t;

    // A write to r0 never produces a value worth forwarding or waiting for
    // when r0 is hardwired.
    function automatic logic reg_match(input logic      we,
                                       input reg_addr_t rd,
                                       input reg_addr_t rs,
                                       input logic      zero_hw);
        return we && (rd == rs) && !(zero_hw && (rd == '0));
    endfunction

endpackage

// File: rtl/hazard_forward_controller_forward_select.sv
// forward_select: per-operand forwarding comparator.
//   rs_i    : source register of the instruction in E
//   m_rec_i : memory-stage destination record
//   w_rec_i : writeback-stage destination record
//   sel_o   : FWD_MEM if M writes rs_i, else FWD_WB if W does, else FWD_REG
module forward_select
    import hazard_pkg::*;
#(
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  reg_addr_t  rs_i,
    input  mw_rec_t    m_rec_i,
    input  mw_rec_t    w_rec_i,
    output logic [1:0] sel_o
);

    // M is checked first: it holds the younger, more recent value.
    always_comb begin
        sel_o = FWD_REG;
        if (reg_match(m_rec_i.reg_write, m_rec_i.rd, rs_i, ZERO_REG_HARDWIRED))
            sel_o = FWD_MEM;
        else if (reg_match(w_rec_i.reg_write, w_rec_i.rd, rs_i, ZERO_REG_HARDWIRED))
            sel_o = FWD_WB;
    end

endmodule

// File: rtl/hazard_forward_controller.sv
// hazard_forward_controller: forwarding selects and stall/flush controls for
// the 5-stage core.
//   clk, rst                 : core clock, synchronous active-high reset
//   validD, rs1D, rs2D, rdD  : decode-stage instruction fields
//   regWriteD, memToRegD     : decode instruction writes rdD / is a load
//   branchTakenE             : branch in E resolved taken this cycle
//   data1/2ForwardSelector   : execute operand mux selects (FWD_* encoding)
//   stallF, stallD           : hold PC / IF-ID register
//   flushD, flushE           : clear IF-ID / bubble into ID-EX
// All outputs are combinational in the current cycle and forced to 0 while
// rst is high. Shadow E/M/W records advance every cycle.
module hazard_forward_controller
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W         = 4,
    parameter int unsigned FLUSH_CYCLES       = 2,
    parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  validD,
    input  logic [REG_ADDR_W-1:0] rs1D,
    input  logic [REG_ADDR_W-1:0] rs2D,
    input  logic [REG_ADDR_W-1:0] rdD,
    input  logic                  regWriteD,
    input  logic                  memToRegD,
    input  logic                  branchTakenE,
    output logic [1:0]            data1ForwardSelector,
    output logic [1:0]            data2ForwardSelector,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  flushD,
    output logic                  flushE
);

    localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);

    e_rec_t    e_q, e_d;
    mw_rec_t   m_q, w_q;
    br_state_t state_q;
    logic [2:0] cnt_q;

    reg_addr_t  rs1_x, rs2_x, rd_x;
    logic       lu, flush_br, flush_e_int, stall_int;
    logic [1:0] sel1, sel2;

    assign rs1_x = REG_AW_MAX'(rs1D);
    assign rs2_x = REG_AW_MAX'(rs2D);
    assign rd_x  = REG_AW_MAX'(rdD);

    // Load in E feeding the decode instruction: its data only exists after M.
    assign lu = validD && e_q.mem_to_reg &&
                (reg_match(e_q.reg_write, e_q.rd, rs1_x, ZERO_REG_HARDWIRED) ||
                 reg_match(e_q.reg_write, e_q.rd, rs2_x, ZERO_REG_HARDWIRED));

    assign flush_br    = branchTakenE || (state_q == BR_FLUSH);
    assign flush_e_int = flush_br || lu;
    // A decode instruction being flushed cannot be waiting on anything.
    assign stall_int   = lu && !flush_br;

    always_comb begin
        e_d = '0;
        if (validD && !flush_e_int)
            e_d = '{rs1: rs1_x, rs2: rs2_x, rd: rd_x,
                    reg_write: regWriteD, mem_to_reg: memToRegD};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= '{rd: e_q.rd, reg_write: e_q.reg_write};
            w_q <= m_q;
        end
    end

    // Branch flush FSM. cnt_q counts remaining flush cycles after the one in
    // which the branch resolved; a new taken branch restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BR_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                BR_IDLE: begin
                    if (branchTakenE && (FLUSH_CYCLES > 1)) begin
                        state_q <= BR_FLUSH;
                        cnt_q   <= CNT_RELOAD;
                    end
                end
                BR_FLUSH: begin
                    if (branchTakenE) begin
                        cnt_q <= CNT_RELOAD;
                    end else if (cnt_q == 3'd1) begin
                        state_q <= BR_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
            endcase
        end
    end

    forward_select #(.ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_fwd1 (
        .rs_i    (e_q.rs1),
        .m_rec_i (m_q),
        .w_rec_i (w_q),
        .sel_o   (sel1)
    );

    forward_select #(.ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_fwd2 (
        .rs_i    (e_q.rs2),
        .m_rec_i (m_q),
        .w_rec_i (w_q),
        .sel_o   (sel2)
    );

    // Ternaries keep outputs clean even while records are still unknown
    // before the first reset edge.
    assign data1ForwardSelector = rst ? FWD_REG : sel1;
    assign data2ForwardSelector = rst ? FWD_REG : sel2;
    assign stallF               = rst ? 1'b0 : stall_int;
    assign stallD               = rst ? 1'b0 : stall_int;
    assign flushD               = rst ? 1'b0 : flush_br;
    assign flushE               = rst ? 1'b0 : flush_e_int;

endmodule

// File: tb/tb_hazard_forward_controller.sv
// Directed bench for hazard_forward_controller (default parameters:
// REG_ADDR_W=4, FLUSH_CYCLES=2, ZERO_REG_HARDWIRED=1).
// Each check compares {sel1, sel2, stallF, stallD, flushD, flushE}.
module tb_hazard_forward_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       validD;
    logic [3:0] rs1D, rs2D, rdD;
    logic       regWriteD, memToRegD, branchTakenE;
    logic [1:0] data1ForwardSelector, data2ForwardSelector;
    logic       stallF, stallD, flushD, flushE;
    logic [7:0] obs;

    int n_vec = 0;
    int n_err = 0;

    hazard_forward_controller dut (
        .clk                  (clk),
        .rst                  (rst),
        .validD               (validD),
        .rs1D                 (rs1D),
        .rs2D                 (rs2D),
        .rdD                  (rdD),
        .regWriteD            (regWriteD),
        .memToRegD            (memToRegD),
        .branchTakenE         (branchTakenE),
        .data1ForwardSelector (data1ForwardSelector),
        .data2ForwardSelector (data2ForwardSelector),
        .stallF               (stallF),
        .stallD               (stallD),
        .flushD               (flushD),
        .flushE               (flushE)
    );

    always #5 clk = ~clk;

    assign obs = {data1ForwardSelector, data2ForwardSelector,
                  stallF, stallD, flushD, flushE};

    task automatic drv(input logic v, input int r1, input int r2, input int d,
                       input logic rw, input logic mtr, input logic br);
        validD       = v;
        rs1D         = 4'(r1);
        rs2D         = 4'(r2);
        rdD          = 4'(d);
        regWriteD    = rw;
        memToRegD    = mtr;
        branchTakenE = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] expv);
        #1;
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    initial begin
        // Reset: outputs held at 0 even with hazards and a branch presented
        rst = 1'b1;
        drv(1, 1, 2, 3, 1, 1, 1);
        chk("rst_before_edge", 8'b0000_0000);
        tick();
        chk("rst_held", 8'b0000_0000);
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst", 8'b0000_0000);
        tick();

        // Back-to-back ALU forwarding of r3
        drv(1, 1, 2, 3, 1, 0, 0);              // I1: r3 <- ...
        chk("alu_i1_in_d", 8'b0000_0000);
        tick();
        drv(1, 3, 4, 6, 1, 0, 0);              // I2 reads r3
        chk("alu_unrelated", 8'b0000_0000);    // E=I1 reads r1/r2
        tick();
        drv(1, 3, 8, 9, 1, 0, 0);              // I3 reads r3
        chk("alu_fwd_mem", 8'b1000_0000);      // E=I2, M=I1
        tick();
        drv(1, 0, 0, 5, 1, 0, 0);              // I4: r5 <- ...
        chk("alu_fwd_wb", 8'b0100_0000);       // E=I3, W=I1
        tick();

        // Double match on r5, operand 2
        drv(1, 0, 0, 5, 1, 0, 0);              // I5: r5 <- ...
        chk("dbl_setup_a", 8'b0000_0000);
        tick();
        drv(1, 12, 5, 13, 1, 0, 0);            // I6 reads r5
        chk("dbl_setup_b", 8'b0000_0000);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("dbl_mem_prio", 8'b0010_0000);     // E=I6, M=I5, W=I4
        tick();

        // Load-use on r2
        drv(1, 1, 1, 2, 1, 1, 0);              // load r2
        chk("lu_load_in_d", 8'b0000_0000);
        tick();
        drv(1, 4, 2, 7, 1, 0, 0);              // user reads r2
        chk("lu_stall", 8'b0000_1101);
        tick();
        chk("lu_one_cycle", 8'b0000_0000);     // E bubble, load in M
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("lu_user_fwd", 8'b0001_0000);      // E=user, W=load
        tick();

        // Zero register never a source
        drv(1, 0, 0, 0, 1, 1, 0);              // load r0
        chk("zr_a", 8'b0000_0000);
        tick();
        drv(1, 0, 0, 0, 1, 0, 0);              // reads r0 behind load to r0
        chk("zr_no_lu", 8'b0000_0000);
        tick();
        drv(1, 0, 0, 1, 1, 0, 0);
        chk("zr_no_fwd_mem", 8'b0000_0000);    // M writes r0
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("zr_no_fwd_wb", 8'b0000_0000);     // M and W write r0
        tick();

        // Branch, FLUSH_CYCLES=2, with a coincident load-use
        drv(1, 0, 0, 6, 1, 1, 0);              // load r6
        chk("br_setup", 8'b0000_0000);
        tick();
        drv(1, 6, 0, 8, 1, 0, 1);              // reads r6, branch taken
        chk("br_cycle1", 8'b0000_0011);
        tick();
        drv(1, 6, 0, 8, 1, 0, 0);
        chk("br_cycle2", 8'b0000_0011);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("br_done", 8'b0000_0000);
        tick();

        // Branch taken again during FLUSH restarts the window
        drv(0, 0, 0, 0, 0, 0, 1);
        chk("rs_cycle1", 8'b0000_0011);
        tick();
        chk("rs_restart", 8'b0000_0011);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("rs_tail", 8'b0000_0011);
        tick();

        // Reset in the middle of a flush
        drv(1, 4, 4, 4, 1, 0, 0);              // X1: r4 <- ...
        chk("rmf_idle", 8'b0000_0000);
        tick();
        drv(1, 4, 4, 4, 1, 0, 1);              // branch taken
        chk("rmf_branch", 8'b0000_0011);
        tick();
        rst = 1'b1;                             // now in FLUSH
        chk("rmf_in_reset", 8'b0000_0000);
        tick();
        rst = 1'b0;
        drv(1, 4, 4, 0, 0, 0, 0);
        chk("rmf_released", 8'b0000_0000);     // IDLE, W not holding X1
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
